// File: rtl/instruction_encoder.sv
// instruction_encoder
// Sequential RV32I encoder, the inverse of the core's instruction decoder.
// Each accepted request carries an abstract operation, register numbers and
// an immediate. The block emits the matching 32-bit instruction word on a
// valid/ready stream. The LI pseudo-op may expand into LUI followed by ADDI.
// An illegal operation or immediate is accepted, emits nothing, and raises
// err_illegal for one cycle.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready depends on out_ready)
//   in_op               operation select (0..37 legal, 38..63 illegal)
//   in_rd/rs1/rs2       register numbers
//   in_imm              immediate, two's complement
//   out_valid/out_ready output word handshake
//   out_instr           encoded instruction word (registered)
//   out_last            word is the final word of its request
//   err_illegal         one-cycle pulse after a rejected request
//   busy                a word is being presented
module instruction_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        err_illegal,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WORD, S_HI} state_t;
  typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_LI} fmt_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  state_t      state, state_next;
  logic [31:0] instr_q, instr_next;
  logic [31:0] pend_q, pend_next;
  logic        err_next;

  fmt_t        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        alt;
  logic        op_ok;
  logic        imm_ok;
  logic        two_word;
  logic [31:0] word0, word1;
  logic        accept;

  // Immediate range tests: a value fits N signed bits when every bit above
  // the sign position equals the sign bit.
  logic        fits12, fits13, fits21, lo_zero;
  logic [19:0] li_hi;

  assign fits12  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13  = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21  = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  assign lo_zero = ~(|in_imm[11:0]);
  // Upper part of LI compensates for ADDI sign-extending the low 12 bits;
  // adding 0x800 only carries into bit 12 when bit 11 is set.
  assign li_hi   = in_imm[31:12] + {19'd0, in_imm[11]};

  // Operation decode: format class, major opcode and funct3.
  always_comb begin
    fmt   = F_R;
    opc   = OPC_OP;
    alt   = 1'b0;
    op_ok = 1'b1;
    case (in_op) inside
      [6'd0:6'd9]:   begin fmt = F_R;  opc = OPC_OP;     end
      [6'd10:6'd15]: begin fmt = F_I;  opc = OPC_IMM;    end
      [6'd16:6'd18]: begin fmt = F_SH; opc = OPC_IMM;    end
      [6'd19:6'd23]: begin fmt = F_I;  opc = OPC_LOAD;   end
      [6'd24:6'd26]: begin fmt = F_S;  opc = OPC_STORE;  end
      [6'd27:6'd32]: begin fmt = F_B;  opc = OPC_BRANCH; end
      6'd33:         begin fmt = F_U;  opc = OPC_LUI;    end
      6'd34:         begin fmt = F_U;  opc = OPC_AUIPC;  end
      6'd35:         begin fmt = F_J;  opc = OPC_JAL;    end
      6'd36:         begin fmt = F_I;  opc = OPC_JALR;   end
      6'd37:         begin fmt = F_LI; opc = OPC_IMM;    end
      default:       op_ok = 1'b0;
    endcase
    // SUB, SRA and SRAI carry the alternate-function bit (instr[30]).
    if (in_op == 6'd1 || in_op == 6'd7 || in_op == 6'd18) alt = 1'b1;
    case (in_op)
      6'd2, 6'd11, 6'd31:                    f3 = 3'd6;
      6'd3, 6'd12, 6'd32:                    f3 = 3'd7;
      6'd4, 6'd13, 6'd22, 6'd29:             f3 = 3'd4;
      6'd5, 6'd16, 6'd20, 6'd25, 6'd28:      f3 = 3'd1;
      6'd6, 6'd7, 6'd17, 6'd18, 6'd23, 6'd30: f3 = 3'd5;
      6'd8, 6'd14, 6'd21, 6'd26:             f3 = 3'd2;
      6'd9, 6'd15:                           f3 = 3'd3;
      default:                               f3 = 3'd0;
    endcase
  end

  // Word assembly per format. Register fields a format lacks simply never
  // appear in its bit layout, which masks them.
  always_comb begin
    word0    = '0;
    word1    = '0;
    two_word = 1'b0;
    imm_ok   = 1'b1;
    case (fmt)
      F_R:  word0 = {1'b0, alt, 5'd0, in_rs2, in_rs1, f3, in_rd, opc};
      F_I: begin
        imm_ok = fits12;
        word0  = {in_imm[11:0], in_rs1, f3, in_rd, opc};
      end
      F_SH: begin
        imm_ok = ~(|in_imm[31:5]);
        word0  = {1'b0, alt, 5'd0, in_imm[4:0], in_rs1, f3, in_rd, opc};
      end
      F_S: begin
        imm_ok = fits12;
        word0  = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
      end
      F_B: begin
        imm_ok = fits13 & ~in_imm[0];
        word0  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                  in_imm[4:1], in_imm[11], opc};
      end
      F_U: begin
        imm_ok = lo_zero;
        word0  = {in_imm[31:12], in_rd, opc};
      end
      F_J: begin
        imm_ok = fits21 & ~in_imm[0];
        word0  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      end
      F_LI: begin
        if (fits12) begin
          word0 = {in_imm[11:0], 5'd0, 3'd0, in_rd, OPC_IMM};
        end else if (lo_zero) begin
          word0 = {in_imm[31:12], in_rd, OPC_LUI};
        end else begin
          two_word = 1'b1;
          word0    = {li_hi, in_rd, OPC_LUI};
          word1    = {in_imm[11:0], in_rd, 3'd0, in_rd, OPC_IMM};
        end
      end
      default: imm_ok = 1'b0;
    endcase
  end

  // Next-state logic. A legal accept always overrides the drain transition,
  // which is what lets back-to-back single words stream at one per cycle.
  always_comb begin
    in_ready   = (state == S_IDLE) || (state == S_WORD && out_ready);
    accept     = in_valid && in_ready;
    state_next = state;
    instr_next = instr_q;
    pend_next  = pend_q;
    err_next   = accept && !(op_ok && imm_ok);
    case (state)
      S_IDLE: state_next = S_IDLE;
      S_WORD: if (out_ready) state_next = S_IDLE;
      S_HI: begin
        if (out_ready) begin
          state_next = S_WORD;
          instr_next = pend_q;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (accept && op_ok && imm_ok) begin
      state_next = two_word ? S_HI : S_WORD;
      instr_next = word0;
      pend_next  = word1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      pend_q      <= '0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_next;
      instr_q     <= instr_next;
      pend_q      <= pend_next;
      err_illegal <= err_next;
    end
  end

  assign out_valid = (state != S_IDLE);
  assign out_last  = (state == S_WORD);
  assign busy      = (state != S_IDLE);
  assign out_instr = instr_q;

endmodule
